// File: rtl/iot_event_sched_pkg.sv
// -----------------------------------------------------------------------------
// iot_pkg
// Shared definitions for the IoT event scheduler slice: FSM state encoding and
// default sizing of the requester vector and the active-device count.
// -----------------------------------------------------------------------------
package iot_pkg;

    localparam int N_DEV_DEF = 4;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RELEASE = 2'd2
    } state_e;

endpackage

// File: rtl/iot_event_sched_if.sv
// -----------------------------------------------------------------------------
// iot_event_sched_if
// Bundles the device request/response lines and the monitor-facing step
// outputs of the scheduler.
//   req, dir        : per-device request and direction (devices -> scheduler)
//   ack, rej        : per-device one-cycle accept / refuse pulses
//   change, on_off  : step strobe and step direction towards the monitor
//   count           : shadow of the monitor count
//   busy            : scheduler is not idle
// master = device/monitor side, slave = scheduler side.
// -----------------------------------------------------------------------------
interface iot_event_sched_if #(
    parameter int N_DEV = iot_pkg::N_DEV_DEF,
    parameter int CNT_W = iot_pkg::CNT_W_DEF
);
    logic [N_DEV-1:0] req;
    logic [N_DEV-1:0] dir;
    logic [N_DEV-1:0] ack;
    logic [N_DEV-1:0] rej;
    logic             change;
    logic             on_off;
    logic [CNT_W-1:0] count;
    logic             busy;

    modport master (
        output req, dir,
        input  ack, rej, change, on_off, count, busy
    );

    modport slave (
        input  req, dir,
        output ack, rej, change, on_off, count, busy
    );
endinterface

// File: rtl/iot_event_sched_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: scans upward from ptr_i, wrapping from
// N_DEV-1 to 0, and returns the first requesting index.
//   req_i   : request vector
//   ptr_i   : scan start index
//   grant_o : one-hot winner (zero when nothing requests)
//   idx_o   : winner index
//   valid_o : any request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N_DEV = iot_pkg::N_DEV_DEF,
    parameter int PTR_W = $clog2(N_DEV)
) (
    input  logic [N_DEV-1:0] req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N_DEV-1:0] grant_o,
    output logic [PTR_W-1:0] idx_o,
    output logic             valid_o
);
    int cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = 0;
        for (int off = 0; off < N_DEV; off++) begin
            cand = (int'(ptr_i) + off) % N_DEV;
            if (!valid_o && req_i[cand]) begin
                valid_o       = 1'b1;
                idx_o         = PTR_W'(cand);
                grant_o[cand] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/iot_event_sched.sv
// -----------------------------------------------------------------------------
// iot_event_sched
// Serialises on/off events from N_DEV devices into single up/down steps for an
// external active-device monitor, keeping a shadow copy of its count and
// refusing steps that would wrap it.
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active high
//   bus  : slave side of iot_event_sched_if (req/dir in; ack/rej/change/
//          on_off/count/busy out)
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for any request; arbiter winner latched on exit
// ISSUE   | one cycle: ack+step or rej for the latched winner
// RELEASE | waiting for the winner to drop its request
// -----------------------------------------------------------------------------
module iot_event_sched #(
    parameter int N_DEV = iot_pkg::N_DEV_DEF,
    parameter int CNT_W = iot_pkg::CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    iot_event_sched_if.slave  bus
);
    import iot_pkg::*;

    localparam int               PTR_W    = $clog2(N_DEV);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_DEV - 1);

    state_e            state_q, state_d;
    logic [PTR_W-1:0]  win_q, win_d;
    logic              dir_q, dir_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [N_DEV-1:0]  arb_grant;
    logic [PTR_W-1:0]  arb_idx;
    logic              arb_valid;

    logic              in_issue;
    logic              step_ok;
    logic [N_DEV-1:0]  win_oh;

    rr_arbiter #(
        .N_DEV (N_DEV),
        .PTR_W (PTR_W)
    ) u_arb (
        .req_i   (bus.req),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            win_q   <= '0;
            dir_q   <= 1'b0;
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            dir_q   <= dir_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    // Guard against wrapping the monitor count in either direction.
    assign step_ok = dir_q ? (count_q != CNT_MAX) : (count_q != '0);

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        dir_d   = dir_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    win_d   = arb_idx;
                    dir_d   = bus.dir[arb_idx];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = RELEASE;
                ptr_d   = (win_q == PTR_LAST) ? '0 : win_q + PTR_W'(1);
                if (step_ok) begin
                    count_d = dir_q ? count_q + CNT_W'(1) : count_q - CNT_W'(1);
                end
            end
            RELEASE: begin
                if (!bus.req[win_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs depend only on registered state so reset clears them at once.
    assign in_issue   = (state_q == ISSUE);
    assign win_oh     = N_DEV'(1) << win_q;
    assign bus.change = in_issue & step_ok;
    assign bus.on_off = bus.change & dir_q;
    assign bus.ack    = bus.change ? win_oh : '0;
    assign bus.rej    = (in_issue & ~step_ok) ? win_oh : '0;
    assign bus.count  = count_q;
    assign bus.busy   = (state_q != IDLE);

endmodule

// File: tb/tb_iot_event_sched.sv
module tb_iot_event_sched;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    int   mon_cnt;
    int   gap_viol;
    logic prev_chg;
    int   lat;

    iot_event_sched_if #(.N_DEV(4), .CNT_W(8)) bus ();

    iot_event_sched #(.N_DEV(4), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench-side monitor counter driven by the step strobe.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mon_cnt  <= 0;
            prev_chg <= 1'b0;
        end else begin
            if (bus.change) mon_cnt <= bus.on_off ? mon_cnt + 1 : mon_cnt - 1;
            if (bus.change && prev_chg) gap_viol <= gap_viol + 1;
            prev_chg <= bus.change;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic do_reset();
        bus.req = '0;
        bus.dir = '0;
        rst     = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Waits (bounded) for the next ack/rej and checks it against expectations.
    task automatic wait_grant(input string tag, input logic [3:0] exp_ack,
                              input logic [3:0] exp_rej, input logic exp_on,
                              input bit drop, output int t);
        t = 0;
        @(negedge clk);
        while (((bus.ack | bus.rej) == 4'b0) && t < 12) begin
            @(negedge clk);
            t++;
        end
        chk({tag, " ack"},    bus.ack,    exp_ack);
        chk({tag, " rej"},    bus.rej,    exp_rej);
        chk({tag, " change"}, bus.change, |exp_ack);
        chk({tag, " on_off"}, bus.on_off, exp_on);
        if (drop) bus.req = bus.req & ~(exp_ack | exp_rej);
    endtask

    task automatic wait_idle(input string tag);
        int t;
        t = 0;
        @(negedge clk);
        while (bus.busy && t < 12) begin
            @(negedge clk);
            t++;
        end
        chk({tag, " idle"}, bus.busy, 1'b0);
    endtask

    task automatic mon_check(input string tag);
        chk({tag, " mon_cnt"}, mon_cnt, 32'(bus.count));
        chk({tag, " chg_gap"}, gap_viol, 0);
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        gap_viol = 0;
        rst      = 1'b1;
        bus.req  = '0;
        bus.dir  = '0;

        // Single on-accept from reset.
        do_reset();
        chk("rst ack",   bus.ack,   4'b0);
        chk("rst busy",  bus.busy,  1'b0);
        chk("rst count", bus.count, 8'd0);
        chk("rst chg",   bus.change, 1'b0);
        bus.req = 4'b0001;
        bus.dir = 4'b0001;
        wait_grant("s1", 4'b0001, 4'b0000, 1'b1, 1'b0, lat);
        chk("s1 latency", lat, 0);
        chk("s1 count@issue", bus.count, 8'd0);
        @(negedge clk);
        chk("s1 count", bus.count, 8'd1);
        chk("s1 busy",  bus.busy,  1'b1);
        chk("s1 ack0",  bus.ack,   4'b0);
        bus.req = 4'b0000;
        wait_idle("s1");
        mon_check("s1");

        // Off request at zero is refused.
        do_reset();
        bus.req = 4'b0001;
        bus.dir = 4'b0000;
        wait_grant("s2", 4'b0000, 4'b0001, 1'b0, 1'b1, lat);
        wait_idle("s2");
        chk("s2 count", bus.count, 8'd0);
        mon_check("s2");

        // All four held; round-robin order.
        do_reset();
        bus.req = 4'b1111;
        bus.dir = 4'b1111;
        wait_grant("rr0", 4'b0001, 4'b0, 1'b1, 1'b1, lat);
        wait_grant("rr1", 4'b0010, 4'b0, 1'b1, 1'b1, lat);
        wait_grant("rr2", 4'b0100, 4'b0, 1'b1, 1'b1, lat);
        wait_grant("rr3", 4'b1000, 4'b0, 1'b1, 1'b1, lat);
        wait_idle("rr");
        chk("rr count", bus.count, 8'd4);
        mon_check("rr");

        // Pointer wrap: after granting 2, search starts at 3 and wraps to 0.
        do_reset();
        bus.req = 4'b0100;
        bus.dir = 4'b0100;
        wait_grant("wr2", 4'b0100, 4'b0, 1'b1, 1'b1, lat);
        wait_idle("wr2");
        bus.req = 4'b0101;
        bus.dir = 4'b0101;
        wait_grant("wrA", 4'b0001, 4'b0, 1'b1, 1'b1, lat);
        wait_grant("wrB", 4'b0100, 4'b0, 1'b1, 1'b1, lat);
        wait_idle("wr");
        chk("wr count", bus.count, 8'd3);
        mon_check("wr");

        // Request dropped before grant is discarded.
        do_reset();
        bus.req = 4'b0001;
        bus.dir = 4'b0011;
        wait_grant("dp0", 4'b0001, 4'b0, 1'b1, 1'b0, lat);
        bus.req[1] = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("dp hold ack", bus.ack, 4'b0);
        end
        bus.req[1] = 1'b0;
        @(negedge clk);
        bus.req[0] = 1'b0;
        wait_idle("dp");
        repeat (3) begin
            @(negedge clk);
            chk("dp quiet", {bus.ack, bus.rej, 3'b0, bus.busy}, 32'd0);
        end
        chk("dp count", bus.count, 8'd1);
        mon_check("dp");

        // Saturation at the top of the count.
        do_reset();
        for (int i = 0; i < 255; i++) begin
            bus.req[0] = 1'b1;
            bus.dir[0] = 1'b1;
            wait_grant("pre", 4'b0001, 4'b0, 1'b1, 1'b1, lat);
            wait_idle("pre");
        end
        chk("sat count255", bus.count, 8'd255);
        bus.req = 4'b0010;
        bus.dir = 4'b0010;
        wait_grant("sat up", 4'b0000, 4'b0010, 1'b0, 1'b1, lat);
        wait_idle("sat up");
        chk("sat hold", bus.count, 8'd255);
        bus.req = 4'b0100;
        bus.dir = 4'b0000;
        wait_grant("sat dn", 4'b0100, 4'b0, 1'b0, 1'b1, lat);
        wait_idle("sat dn");
        chk("sat count254", bus.count, 8'd254);
        mon_check("sat");

        // Reset during ISSUE aborts and clears the pointer.
        do_reset();
        bus.req = 4'b0001;
        bus.dir = 4'b0011;
        wait_grant("ra0", 4'b0001, 4'b0, 1'b1, 1'b1, lat);
        wait_idle("ra0");
        chk("ra count1", bus.count, 8'd1);
        bus.req = 4'b0010;
        wait_grant("ra1", 4'b0010, 4'b0, 1'b1, 1'b0, lat);
        rst = 1'b1;
        #1;
        chk("ra ack",   bus.ack,    4'b0);
        chk("ra chg",   bus.change, 1'b0);
        chk("ra count", bus.count,  8'd0);
        chk("ra busy",  bus.busy,   1'b0);
        bus.req = 4'b0011;
        @(negedge clk);
        rst = 1'b0;
        wait_grant("ra ptr", 4'b0001, 4'b0, 1'b1, 1'b1, lat);
        wait_grant("ra nxt", 4'b0010, 4'b0, 1'b1, 1'b1, lat);
        wait_idle("ra");
        chk("ra count2", bus.count, 8'd2);
        mon_check("ra");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/iot_event_sched.md
IOT_EVENT_SCHED -- requirements
Module: iot_event_sched

Interface
REQ-001 Parameter N_DEV, default 4, number of device requesters (2..8).
REQ-002 Parameter CNT_W, default 8, width of the active-device count.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 req  input  N_DEV  per-device request; held high until acknowledged.
REQ-006 dir  input  N_DEV  per-device direction; 1 = device turning on, 0 = turning off; stable while req high.
REQ-007 ack  output  N_DEV  one-cycle pulse: request accepted and applied.
REQ-008 rej  output  N_DEV  one-cycle pulse: request refused by count guard.
REQ-009 change  output  1  to monitor; 1 = step count this cycle, 0 = hold.
REQ-010 on_off  output  1  to monitor; step direction, 1 = up, 0 = down; valid when change=1.
REQ-011 count  output  CNT_W  shadow of monitor count after all issued steps.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 FSM states IDLE, ISSUE, RELEASE; all outputs decoded from registers only.
REQ-014 IDLE: at a clock edge with any req bit high, the round-robin arbiter picks a winner, latches its index and dir, goes to ISSUE.
REQ-015 Round-robin: search starts at pointer ptr, ascending, wrapping N_DEV-1 -> 0; lowest-index bit at or after ptr wins.
REQ-016 ISSUE lasts exactly one cycle; next state is RELEASE; ptr becomes winner+1 modulo N_DEV.
REQ-017 Accept in ISSUE: change=1, on_off=latched dir, ack[winner]=1; count updates by +1/-1 at the ISSUE-exit edge.
REQ-018 Guard: dir=1 with count = 2^CNT_W-1, or dir=0 with count = 0, is refused: change=0, rej[winner]=1, count unchanged.
REQ-019 Count never wraps; arithmetic is CNT_W bits unsigned.
REQ-020 RELEASE: remain until req[winner]=0, then IDLE; other requests wait.
REQ-021 Latency req rise (idle block) -> ack/change = 1 cycle; minimum spacing between two grants = 3 cycles.
REQ-022 Simultaneous requests: exactly one granted per ISSUE; ack/rej are one-hot or zero.
REQ-023 req bits dropped before grant are discarded without ack/rej.
REQ-024 Outside ISSUE, change, on_off, ack, rej are 0.

Reset
REQ-025 rst high: state IDLE, ptr 0, count 0, change/on_off/ack/rej 0, busy 0, immediately and independent of clk.
REQ-026 Reset mid-ISSUE or mid-RELEASE aborts the transaction; no ack/rej emitted; after release the first grant obeys REQ-014 with ptr 0.

Structure
REQ-027 Shared package iot_pkg holds state enum (IDLE, ISSUE, RELEASE) and default CNT_W/N_DEV constants.
REQ-028 One sub-module rr_arbiter (req vector + ptr in, one-hot grant + index out, combinational).
REQ-029 Implementation 120-400 RTL lines; monitor counter is not instantiated inside.

Verification
REQ-030 Reset then req=0001, dir=0001 -> cycle 1 change=1, on_off=1, ack=0001; count 0->1; busy until req drops.
REQ-031 From reset req=0001, dir=0000 -> rej=0001, change=0, count stays 0.
REQ-032 req=1111 held and each dropped after its ack, all dir=1 -> ack order 0001, 0010, 0100, 1000; count 4.
REQ-033 Preload count to 255 (255 on-accepts), then dir=1 request -> rej pulse, count 255; dir=0 request -> ack, count 254.
REQ-034 Assert rst during ISSUE -> ack=0, change=0, count 0 same instant; ptr 0 after release.
REQ-035 Bench-attached monitor model: after every scenario monitor counter equals count, change pulses never in consecutive cycles.
